// File: rtl/rgb_pkg.sv
// Shared types and helpers for the RGB scene sequencer.
package rgb_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    FADE   = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Scene-table entry layout at the default width; matches wr_data {ch2,ch1,ch0}.
  typedef struct packed {
    logic [DEF_WIDTH-1:0] ch2;
    logic [DEF_WIDTH-1:0] ch1;
    logic [DEF_WIDTH-1:0] ch0;
  } scene_t;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DOWN = 2'd2
  } step_t;

  // Direction one channel must move to approach its target.
  function automatic step_t step_dir(input logic [31:0] level, input logic [31:0] target);
    if (level < target) return STEP_UP;
    if (level > target) return STEP_DOWN;
    return STEP_NONE;
  endfunction

endpackage

// File: rtl/rgb_tick_prescaler.sv
// Free-running tick generator: one-cycle tick every TICK_DIV cycles while run is high.
module rgb_tick_prescaler #(
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = run && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rgb_scene_sequencer.sv
// Drives the three PWM levels either straight from the encoders or by fading
// through a programmable table of colour scenes with a hold time per scene.
module rgb_scene_sequencer
  import rgb_pkg::*;
#(
  parameter int unsigned NUM_SCENES = 4,
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned TICK_DIV   = 1000,
  parameter int unsigned HOLD_W     = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [WIDTH-1:0]              enc_level0,
  input  logic [WIDTH-1:0]              enc_level1,
  input  logic [WIDTH-1:0]              enc_level2,
  input  logic                          mode_auto,
  input  logic [HOLD_W-1:0]             hold_ticks,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_SCENES)-1:0] wr_addr,
  input  logic [3*WIDTH-1:0]            wr_data,
  output logic [WIDTH-1:0]              level0,
  output logic [WIDTH-1:0]              level1,
  output logic [WIDTH-1:0]              level2,
  output logic [$clog2(NUM_SCENES)-1:0] scene_idx,
  output logic                          fading,
  output logic                          scene_reached
);

  localparam int unsigned IDX_W = $clog2(NUM_SCENES);
  localparam int unsigned NCH   = 3;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d, next_idx;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               fading_q, fading_d;
  logic               reached_q, reached_d;
  logic [WIDTH-1:0]   lvl_q [NCH];
  logic [WIDTH-1:0]   lvl_d [NCH];
  logic [WIDTH-1:0]   tgt_q [NCH];
  logic [WIDTH-1:0]   tgt_d [NCH];
  logic [WIDTH-1:0]   enc   [NCH];
  logic [3*WIDTH-1:0] tbl_q [NUM_SCENES];
  logic [3*WIDTH-1:0] tbl_d [NUM_SCENES];
  logic               all_eq;
  logic               tick;
  logic               pre_clr;
  logic               pre_run;

  assign enc[0] = enc_level0;
  assign enc[1] = enc_level1;
  assign enc[2] = enc_level2;

  // Prescaler is held at zero in MANUAL so the first tick lands TICK_DIV cycles into a fade.
  assign pre_clr = (state_q == MANUAL);
  assign pre_run = (state_q != MANUAL);

  rgb_tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (pre_clr),
    .run  (pre_run),
    .tick (tick)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    reached_d = 1'b0;
    lvl_d     = lvl_q;
    tgt_d     = tgt_q;
    tbl_d     = tbl_q;
    next_idx  = idx_q + IDX_W'(1);
    all_eq    = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      if (lvl_q[c] != tgt_q[c]) all_eq = 1'b0;
    end

    case (state_q)
      MANUAL: begin
        lvl_d = enc;
        if (mode_auto) begin
          state_d = FADE;
          for (int c = 0; c < NCH; c++) tgt_d[c] = tbl_q[idx_q][c*WIDTH +: WIDTH];
        end
      end
      FADE: begin
        if (all_eq) begin
          reached_d = 1'b1;
          state_d   = HOLD;
          hold_d    = hold_ticks;
        end else if (tick) begin
          for (int c = 0; c < NCH; c++) begin
            case (step_dir(32'(lvl_q[c]), 32'(tgt_q[c])))
              STEP_UP:   lvl_d[c] = lvl_q[c] + WIDTH'(1);
              STEP_DOWN: lvl_d[c] = lvl_q[c] - WIDTH'(1);
              default:   lvl_d[c] = lvl_q[c];
            endcase
          end
        end
      end
      HOLD: begin
        if (hold_q == '0) begin
          idx_d   = next_idx;
          state_d = FADE;
          for (int c = 0; c < NCH; c++) tgt_d[c] = tbl_q[next_idx][c*WIDTH +: WIDTH];
        end else if (tick) begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      default: state_d = MANUAL;
    endcase

    // Dropping auto mode wins over any scene progress but keeps the scene index.
    if ((state_q != MANUAL) && !mode_auto) begin
      state_d = MANUAL;
      idx_d   = idx_q;
      lvl_d   = enc;
    end

    if (wr_en) tbl_d[wr_addr] = wr_data;

    fading_d = (state_d == FADE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MANUAL;
      idx_q     <= '0;
      hold_q    <= '0;
      fading_q  <= 1'b0;
      reached_q <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        lvl_q[c] <= '0;
        tgt_q[c] <= '0;
      end
      for (int s = 0; s < NUM_SCENES; s++) tbl_q[s] <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      fading_q  <= fading_d;
      reached_q <= reached_d;
      lvl_q     <= lvl_d;
      tgt_q     <= tgt_d;
      tbl_q     <= tbl_d;
    end
  end

  assign level0        = lvl_q[0];
  assign level1        = lvl_q[1];
  assign level2        = lvl_q[2];
  assign scene_idx     = idx_q;
  assign fading        = fading_q;
  assign scene_reached = reached_q;

endmodule

// File: tb/tb_rgb_scene_sequencer.sv
// Randomized self-checking bench for rgb_scene_sequencer against a scene-level reference model.
module tb_rgb_scene_sequencer;
  import rgb_pkg::*;

  localparam int TD = 4;
  localparam int NS = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] enc_level0, enc_level1, enc_level2;
  logic       mode_auto;
  logic [7:0] hold_ticks;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [23:0] wr_data;
  logic [7:0] level0, level1, level2;
  logic [1:0] scene_idx;
  logic       fading, scene_reached;
  logic [27:0] obs;

  int n_cmp = 0;
  int n_bad = 0;

  rgb_scene_sequencer #(.NUM_SCENES(NS), .WIDTH(8), .TICK_DIV(TD), .HOLD_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .enc_level0(enc_level0), .enc_level1(enc_level1), .enc_level2(enc_level2),
    .mode_auto(mode_auto), .hold_ticks(hold_ticks),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .level0(level0), .level1(level1), .level2(level2),
    .scene_idx(scene_idx), .fading(fading), .scene_reached(scene_reached)
  );

  always #5 clk = ~clk;

  assign obs = {level2, level1, level0, scene_idx, fading, scene_reached};

  // Reference model: m_st 0=manual, 1=fading, 2=holding.
  int m_st, m_idx, m_pre, m_hold, m_fad, m_rch;
  int m_lvl[3];
  int m_tgt[3];
  int m_tbl[NS][3];

  task automatic model_reset();
    m_st = 0; m_idx = 0; m_pre = 0; m_hold = 0; m_fad = 0; m_rch = 0;
    for (int c = 0; c < 3; c++) begin m_lvl[c] = 0; m_tgt[c] = 0; end
    for (int s = 0; s < NS; s++) for (int c = 0; c < 3; c++) m_tbl[s][c] = 0;
  endtask

  task automatic model_next();
    int enc[3];
    int n_lvl[3];
    int n_tgt[3];
    int n_st, n_idx, n_hold, n_rch, n_pre;
    bit tick, done;
    enc[0] = int'(enc_level0); enc[1] = int'(enc_level1); enc[2] = int'(enc_level2);
    n_st = m_st; n_idx = m_idx; n_hold = m_hold; n_rch = 0;
    for (int c = 0; c < 3; c++) begin n_lvl[c] = m_lvl[c]; n_tgt[c] = m_tgt[c]; end
    tick  = (m_st != 0) && (m_pre == TD - 1);
    n_pre = (m_st == 0 || tick) ? 0 : m_pre + 1;
    done  = 1'b1;
    for (int c = 0; c < 3; c++) if (m_lvl[c] != m_tgt[c]) done = 1'b0;
    if (m_st == 0) begin
      for (int c = 0; c < 3; c++) n_lvl[c] = enc[c];
      if (mode_auto) begin
        n_st = 1;
        for (int c = 0; c < 3; c++) n_tgt[c] = m_tbl[m_idx][c];
      end
    end else if (m_st == 1) begin
      if (done) begin
        n_rch = 1; n_st = 2; n_hold = int'(hold_ticks);
      end else if (tick) begin
        for (int c = 0; c < 3; c++)
          n_lvl[c] = m_lvl[c] + ((m_tgt[c] > m_lvl[c]) ? 1 : 0) - ((m_tgt[c] < m_lvl[c]) ? 1 : 0);
      end
    end else begin
      if (m_hold == 0) begin
        n_idx = (m_idx + 1) % NS; n_st = 1;
        for (int c = 0; c < 3; c++) n_tgt[c] = m_tbl[n_idx][c];
      end else if (tick) begin
        n_hold = m_hold - 1;
      end
    end
    if (m_st != 0 && !mode_auto) begin
      n_st = 0; n_idx = m_idx;
      for (int c = 0; c < 3; c++) n_lvl[c] = enc[c];
    end
    if (wr_en) for (int c = 0; c < 3; c++) m_tbl[wr_addr][c] = int'(wr_data[c*8 +: 8]);
    m_st = n_st; m_idx = n_idx; m_hold = n_hold; m_rch = n_rch; m_pre = n_pre;
    m_fad = (n_st == 1) ? 1 : 0;
    for (int c = 0; c < 3; c++) begin m_lvl[c] = n_lvl[c]; m_tgt[c] = n_tgt[c]; end
  endtask

  function automatic logic [27:0] exp_obs();
    return {8'(m_lvl[2]), 8'(m_lvl[1]), 8'(m_lvl[0]), 2'(m_idx), 1'(m_fad), 1'(m_rch)};
  endfunction

  task automatic step();
    model_next();
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic wr_slot(input int a, input int c0, input int c1, input int c2);
    scene_t sc;
    sc.ch0 = 8'(c0); sc.ch1 = 8'(c1); sc.ch2 = 8'(c2);
    wr_en = 1'b1; wr_addr = 2'(a); wr_data = sc;
  endtask

  task automatic set_enc(input int a, input int b, input int c);
    enc_level0 = 8'(a); enc_level1 = 8'(b); enc_level2 = 8'(c);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode_auto = 1'b0; hold_ticks = 8'd0; wr_en = 1'b0;
    wr_addr = 2'd0; wr_data = 24'd0; set_enc(0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      set_enc($urandom_range(1, 255), $urandom_range(1, 255), $urandom_range(1, 255));
      mode_auto = (i >= 4);
      step();
      n_cmp++;
      if (obs !== exp_obs()) begin n_bad++; $display("FAIL pre_reset cyc=%0d got=%h exp=%h", i, obs, exp_obs()); end
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 28'd0) begin n_bad++; $display("FAIL async_reset got=%h exp=0", obs); end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    mode_auto = 1'b0; set_enc(8'h37, 0, 0);
    step();
    n_cmp++;
    if (level0 !== 8'h37 || obs !== exp_obs()) begin
      n_bad++; $display("FAIL passthrough got=%h exp=%h", obs, exp_obs());
    end
  endtask

  task automatic test_first_fade();
    int pulses = 0;
    set_enc(0, 0, 0); mode_auto = 1'b0;
    step();
    wr_slot(0, 10, 0, 5); hold_ticks = 8'd2;
    step();
    mode_auto = 1'b1;
    step();
    for (int n = 1; n <= 48; n++) begin
      step();
      if (scene_reached === 1'b1) pulses++;
      n_cmp++;
      if (obs !== exp_obs()) begin n_bad++; $display("FAIL first_fade n=%0d got=%h exp=%h", n, obs, exp_obs()); end
      if (n == 39) begin
        n_cmp++;
        if (level0 !== 8'd9) begin n_bad++; $display("FAIL fade_pre n=39 level0=%0d exp=9", level0); end
      end
      if (n == 40) begin
        n_cmp++;
        if (level0 !== 8'd10 || level2 !== 8'd5 || fading !== 1'b1) begin
          n_bad++; $display("FAIL fade_done level0=%0d level2=%0d fading=%b exp 10 5 1", level0, level2, fading);
        end
      end
    end
    n_cmp++;
    if (pulses != 1) begin n_bad++; $display("FAIL reached_count got=%0d exp=1", pulses); end
    n_cmp++;
    if (scene_idx !== 2'd0 || fading !== 1'b0) begin
      n_bad++; $display("FAIL hold_len idx=%0d fading=%b exp 0 0", scene_idx, fading);
    end
    step();
    n_cmp++;
    if (scene_idx !== 2'd1 || fading !== 1'b1) begin
      n_bad++; $display("FAIL advance idx=%0d fading=%b exp 1 1", scene_idx, fading);
    end
  endtask

  task automatic test_hold_wrap();
    bit wrapped = 1'b0;
    bit seen = 1'b0;
    logic [1:0] prev;
    for (int s = 1; s < NS; s++) begin
      wr_slot(s, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
      step();
    end
    prev = scene_idx;
    for (int i = 0; i < 600; i++) begin
      step();
      if (prev == 2'd3 && scene_idx == 2'd0) wrapped = 1'b1;
      prev = scene_idx;
      n_cmp++;
      if (obs !== exp_obs()) begin n_bad++; $display("FAIL hold_wrap i=%0d got=%h exp=%h", i, obs, exp_obs()); end
    end
    n_cmp++;
    if (!wrapped) begin n_bad++; $display("FAIL wrap got=0 exp=1"); end
    hold_ticks = 8'd0;
    for (int i = 0; i < 300 && !seen; i++) begin
      step();
      if (scene_reached === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL hold0_timeout got=0 exp=1"); end
    step();
    n_cmp++;
    if (fading !== 1'b1 || obs !== exp_obs()) begin
      n_bad++; $display("FAIL hold0_refade got=%h exp=%h", obs, exp_obs());
    end
  endtask

  task automatic test_down_noop();
    mode_auto = 1'b0; set_enc(10, 0, 0);
    step();
    wr_slot(m_idx, 7, 0, 0); hold_ticks = 8'd3;
    step();
    mode_auto = 1'b1;
    step();
    for (int n = 1; n <= 13; n++) begin
      step();
      n_cmp++;
      if (obs !== exp_obs() || level0 < 8'd7) begin n_bad++; $display("FAIL down_fade n=%0d got=%h exp=%h", n, obs, exp_obs()); end
      if (n == 12) begin
        n_cmp++;
        if (level0 !== 8'd7) begin n_bad++; $display("FAIL down_end level0=%0d exp=7", level0); end
      end
    end
    n_cmp++;
    if (scene_reached !== 1'b1) begin n_bad++; $display("FAIL down_reached got=%b exp=1", scene_reached); end
    mode_auto = 1'b0; set_enc(7, 0, 0);
    step();
    mode_auto = 1'b1;
    step();
    step();
    n_cmp++;
    if (scene_reached !== 1'b1 || level0 !== 8'd7 || obs !== exp_obs()) begin
      n_bad++; $display("FAIL noop_fade got=%h exp=%h", obs, exp_obs());
    end
  endtask

  task automatic test_write_during_fade();
    int cur, nxt;
    bit seen;
    mode_auto = 1'b0; set_enc(0, 0, 0);
    cur = m_idx; nxt = (m_idx + 1) % NS;
    wr_slot(cur, 0, 0, 0);
    step();
    wr_slot(nxt, 8, 8, 8); hold_ticks = 8'd0;
    step();
    mode_auto = 1'b1;
    for (int i = 0; i < 8; i++) step();
    wr_slot(nxt, 255, 255, 255);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step();
      n_cmp++;
      if (obs !== exp_obs()) begin n_bad++; $display("FAIL wr_fade i=%0d got=%h exp=%h", i, obs, exp_obs()); end
      if (scene_reached === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen || level0 !== 8'd8 || level2 !== 8'd8) begin
      n_bad++; $display("FAIL old_target level0=%0d level2=%0d exp=8", level0, level2);
    end
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      step();
      n_cmp++;
      if (obs !== exp_obs()) begin n_bad++; $display("FAIL wr_revisit i=%0d got=%h exp=%h", i, obs, exp_obs()); end
      if (scene_reached === 1'b1 && scene_idx == 2'(nxt)) seen = 1'b1;
    end
    n_cmp++;
    if (!seen || level0 !== 8'd255 || level1 !== 8'd255) begin
      n_bad++; $display("FAIL new_target seen=%b level0=%0d exp=255", seen, level0);
    end
  endtask

  task automatic test_mode_drop();
    logic [1:0] saved;
    bit got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      step();
      if (fading === 1'b1 && m_pre == 2) got = 1'b1;
    end
    n_cmp++;
    if (!got) begin n_bad++; $display("FAIL drop_wait_timeout got=0 exp=1"); end
    saved = scene_idx;
    mode_auto = 1'b0; set_enc(1, 2, 3);
    step();
    n_cmp++;
    if (level0 !== 8'd1 || level1 !== 8'd2 || level2 !== 8'd3 || fading !== 1'b0 || scene_idx !== saved) begin
      n_bad++; $display("FAIL mode_drop got=%h exp=%h", obs, exp_obs());
    end
    mode_auto = 1'b1;
    step();
    n_cmp++;
    if (fading !== 1'b1 || scene_idx !== saved) begin
      n_bad++; $display("FAIL resume fading=%b idx=%0d exp 1 %0d", fading, scene_idx, saved);
    end
    for (int i = 0; i < 60; i++) begin
      step();
      n_cmp++;
      if (obs !== exp_obs()) begin n_bad++; $display("FAIL resume_run i=%0d got=%h exp=%h", i, obs, exp_obs()); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 60) == 0) mode_auto = ~mode_auto;
      if ($urandom_range(0, 9) == 0)
        wr_slot($urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
      if ($urandom_range(0, 19) == 0) hold_ticks = 8'($urandom_range(0, 3));
      set_enc($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
      step();
      n_cmp++;
      if (obs !== exp_obs()) begin n_bad++; $display("FAIL random i=%0d got=%h exp=%h", i, obs, exp_obs()); end
    end
  endtask

  initial begin
    test_reset();
    test_first_fade();
    test_hold_wrap();
    test_down_noop();
    test_write_during_fade();
    test_mode_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rgb_scene_sequencer.md
Name: rgb_scene_sequencer

Overview:
Controller that sequences the three PWM level inputs of the RGB mixer datapath.
- Manual mode: passes the encoder-derived levels straight through.
- Auto mode: steps through a small table of programmed colour scenes, fading linearly one LSB per tick and holding each scene for a programmable number of ticks.
- Sits between the encoder counters and the PWM generators inside the mixer top.

Parameters:
NUM_SCENES, 4, number of scene slots (power of 2, >=2)
WIDTH, 8, bits per colour channel level
TICK_DIV, 1000, clock cycles per fade/hold tick (>=2)
HOLD_W, 8, width of hold-time count

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock, reset is asynchronous and active-low
enc_level0/1/2  in  WIDTH each  manual levels from the encoder counters
mode_auto  in  1  1=sequence scenes, 0=manual passthrough
hold_ticks  in  HOLD_W  ticks to hold each scene after its fade completes
wr_en  in  1  scene-table write strobe
wr_addr  in  $clog2(NUM_SCENES)  scene slot to write
wr_data  in  3*WIDTH  {ch2,ch1,ch0} levels for the slot
level0/1/2  out  WIDTH each  levels to the PWM generators (registered)
scene_idx  out  $clog2(NUM_SCENES)  scene currently targeted
fading  out  1  high while in FADE
scene_reached  out  1  one-cycle pulse when all channels reach the target

Behaviour:
- Reset (async, rst_n=0):
  - level0..2=0, scene_idx=0, state=MANUAL.
  - Prescaler=0, hold counter=0, all scene slots=0.
  - fading=0, scene_reached=0.
- Scene table: register array.
  - A write occurs on the clk edge with wr_en=1 and is accepted in any state.
  - Target registers latch from the table only when FADE is entered.
  - A write to the slot being latched on the same edge yields the pre-write value.
  - Writes during FADE/HOLD do not affect the current target.
- Tick: prescaler counts 0..TICK_DIV-1 and runs only in FADE/HOLD.
  - tick=1 on the cycle the count equals TICK_DIV-1; the count then wraps to 0.
  - Prescaler clears on MANUAL->FADE, so the first tick occurs TICK_DIV cycles after entry.
- States:
  - MANUAL:
    - levelN <= enc_levelN every cycle (1-cycle latency).
    - mode_auto=1 -> FADE, latching target = table[scene_idx] (scene_idx unchanged).
  - FADE, on each tick, per channel:
    - levelN<target: +1.
    - levelN>target: -1.
    - levelN==target: hold.
    - Arithmetic is saturation-free; the +/-1 step never overshoots.
    - When all three equal target (evaluated every cycle, including on entry): pulse scene_reached for 1 cycle -> HOLD, hold counter <= hold_ticks.
  - HOLD:
    - On tick, if counter != 0, decrement.
    - When counter==0 (immediately if hold_ticks==0):
      - scene_idx <= scene_idx+1, wrapping NUM_SCENES-1 -> 0.
      - Latch target = table[next idx] -> FADE.
      - Prescaler is not cleared.
- mode_auto=0 in FADE or HOLD:
  - Next edge -> MANUAL; levels take enc_levelN from that edge; prescaler clears.
  - scene_idx is retained, so resuming auto re-targets the same scene.
- fading = (state==FADE), registered together with the state.
- Fade duration = max|levelN - targetN| * TICK_DIV cycles.
- Simultaneous events:
  - tick and target reached on the same cycle: the step is applied first; the reached check uses post-step values next cycle.
  - mode_auto falling on the same cycle as scene_reached: MANUAL wins, and the pulse still fires.
- hold_ticks is sampled on entry to HOLD only.

Decomposition:
- Shared package rgb_pkg:
  - WIDTH default.
  - State enum {MANUAL, FADE, HOLD}.
  - Scene typedef (packed 3xWIDTH struct).
- One sub-module: rgb_tick_prescaler, with ports clk, rst_n, clr, run, tick out; parameter TICK_DIV.
- The per-channel step compare is a function in rgb_pkg.

Test Plan (TICK_DIV=4, WIDTH=8, NUM_SCENES=4):
1. Reset value and passthrough latency:
   - Assert rst_n=0 mid-run -> all outputs 0 asynchronously.
   - Release, mode_auto=0, enc_level0=0x37 -> level0=0x37 one cycle later.
2. First fade:
   - Write slot0={5,0,10}, hold_ticks=2, mode_auto 0->1 from levels 0.
   - level0 increments every 4 cycles, reaches 10 at cycle 40 after entry; level2 stops at 5.
   - scene_reached pulses once; fading drops.
3. Hold, advance and wrap:
   - Program slots 1-3.
   - HOLD lasts 2 ticks (8 cycles), then scene_idx 0->1.
   - After scene 3, scene_idx wraps to 0.
   - hold_ticks=0 -> FADE re-entered on the cycle after scene_reached.
4. Downward fade and no-op fade:
   - From {0,0,10}, target slot={0,0,7} -> level0 decrements 3 ticks, no overshoot.
   - Target equal to current -> scene_reached on the entry cycle, no ticks consumed.
5. Write during fade:
   - While fading to slot1, write slot1={255,255,255} -> fade completes at the old slot1 value.
   - On the next visit to slot1, the new value is used.
6. Mode drop mid-fade:
   - mode_auto=0 during FADE, enc_levels={1,2,3} -> next cycle levels={1,2,3}, fading=0, scene_idx retained.
   - Re-enabling auto fades to the same scene.
